// File: rtl/virtual_gamepak_responder.sv
// virtual_gamepak_responder: MBC1-style cartridge target that serves GamePak bus cycles
// from a ROM/RAM image in backing memory, stalling the core with Delay until the byte returns.
module virtual_gamepak_responder #(
  parameter int ROM_ADDR_W = 21,
  parameter int RAM_ADDR_W = 15,
  parameter int MEM_ADDR_W = 23,
  parameter logic [MEM_ADDR_W-1:0] RAM_BASE = MEM_ADDR_W'('h200000)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clk_en,
  input  logic                  i_cs,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [15:0]           i_address,
  input  logic [7:0]            i_data_out,
  output logic [7:0]            o_data_in,
  output logic                  o_delay,
  output logic                  o_audio,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata,
  input  logic                  i_mem_ack
);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  localparam logic [MEM_ADDR_W-1:0] ROM_MASK = MEM_ADDR_W'((64'd1 << ROM_ADDR_W) - 64'd1);
  state_t r_state, w_state_nx;
  logic [7:0] r_data_in, w_data_nx, r_mem_wdata, w_wdata_nx;
  logic r_delay, w_delay_nx, r_mem_req, w_req_nx, r_mem_we, w_we_nx;
  logic [MEM_ADDR_W-1:0] r_mem_addr, w_addr_nx, w_rom_addr, w_ram_addr;
  logic [4:0] r_rom_bank, w_rom_bank_nx, w_bank_eff;
  logic [1:0] r_ram_bank, w_ram_bank_nx;
  logic r_ram_en, w_ram_en_nx;
  logic w_acc, w_ram_win, w_mem, w_map_wr;
  assign w_acc      = (r_state == S_IDLE) & i_clk_en & i_cs & (i_read ^ i_write);
  assign w_ram_win  = i_address[15:13] == 3'b101;
  assign w_mem      = w_acc & ((i_read & ~i_address[15]) | (w_ram_win & r_ram_en));
  assign w_map_wr   = w_acc & i_write & ~i_address[15];
  // Bank 0 in the switchable window aliases to bank 1, as on a real MBC1.
  assign w_bank_eff = ~i_address[14] ? 5'd0 : (r_rom_bank == 5'd0) ? 5'd1 : r_rom_bank;
  assign w_rom_addr = MEM_ADDR_W'({w_bank_eff, i_address[13:0]}) & ROM_MASK;
  assign w_ram_addr = RAM_BASE + MEM_ADDR_W'(RAM_ADDR_W'({r_ram_bank, i_address[12:0]}));
  always_comb begin
    w_state_nx    = r_state;
    w_data_nx     = r_data_in;
    w_delay_nx    = r_delay;
    w_req_nx      = r_mem_req;
    w_we_nx       = r_mem_we;
    w_addr_nx     = r_mem_addr;
    w_wdata_nx    = r_mem_wdata;
    w_ram_en_nx   = (w_map_wr & i_address[14:13] == 2'd0) ? (i_data_out[3:0] == 4'hA) : r_ram_en;
    w_rom_bank_nx = (w_map_wr & i_address[14:13] == 2'd1) ? i_data_out[4:0] : r_rom_bank;
    w_ram_bank_nx = (w_map_wr & i_address[14:13] == 2'd2) ? i_data_out[1:0] : r_ram_bank;
    if (r_state == S_IDLE) begin
      if (w_mem) begin
        w_state_nx = S_REQ;
        w_req_nx   = 1'b1;
        w_delay_nx = 1'b1;
        w_we_nx    = i_write;
        w_addr_nx  = i_address[15] ? w_ram_addr : w_rom_addr;
        w_wdata_nx = i_data_out;
      end else if (w_acc & i_read) begin
        w_data_nx = 8'hFF;
      end
    end else if (i_mem_ack) begin
      w_state_nx = S_IDLE;
      w_req_nx   = 1'b0;
      w_delay_nx = 1'b0;
      w_data_nx  = r_mem_we ? r_data_in : i_mem_rdata;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_data_in   <= 8'hFF;
      r_delay     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_rom_bank  <= 5'd1;
      r_ram_bank  <= 2'd0;
      r_ram_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_data_in   <= w_data_nx;
      r_delay     <= w_delay_nx;
      r_mem_req   <= w_req_nx;
      r_mem_we    <= w_we_nx;
      r_mem_addr  <= w_addr_nx;
      r_mem_wdata <= w_wdata_nx;
      r_rom_bank  <= w_rom_bank_nx;
      r_ram_bank  <= w_ram_bank_nx;
      r_ram_en    <= w_ram_en_nx;
    end
  end
  assign o_data_in   = r_data_in;
  assign o_delay     = r_delay;
  assign o_audio     = 1'b0;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
endmodule
